mm_result_checker: RTL

//  Downstream self-check stage for the matrix multiplier top. Arms on i_en, waits for the

---
 rtl/mm_result_checker_pkg.sv | 24 ++
 rtl/mm_result_checker_busy_fall_det.sv | 21 ++
 rtl/mm_result_checker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mm_result_checker_pkg.sv
// Shared definitions for the matrix-multiplier result checker: default geometry,
// FSM state encoding and a saturating counter helper.
package mm_result_checker_pkg;

    localparam int unsigned MM_ADDR_W    = 16;
    localparam int unsigned MM_DATA_W    = 8;
    localparam logic [15:0] MM_BASE_ADDR = 16'h0024;
    localparam int unsigned MM_NUM_ELEMS = 18;

    // Index value reported when a check saw no mismatch.
    localparam logic [7:0] MM_NO_ERR_IDX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mm_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mm_result_checker_busy_fall_det.sv
// Registers the multiplier busy flag and flags the cycle in which it falls.
module mm_busy_fall_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_busy,
    output logic o_fall
);

    logic r_busy_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= i_busy;
        end
    end

    assign o_fall = r_busy_q & ~i_busy;

endmodule

// File: rtl/mm_result_checker.sv
// On-chip result checker: after the multiplier busy flag falls, streams the result
// region out of DRAM, compares each byte with the expected ROM and reports the outcome.
module mm_result_checker
    import mm_result_checker_pkg::*;
#(
    parameter int unsigned         ADDR_W    = MM_ADDR_W,
    parameter int unsigned         DATA_W    = MM_DATA_W,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = ADDR_W'(MM_BASE_ADDR),
    parameter int unsigned         NUM_ELEMS = MM_NUM_ELEMS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_mm_busy,
    output logic              o_dram_read,
    output logic [ADDR_W-1:0] o_dram_addr,
    input  logic [DATA_W-1:0] i_dram_data,
    output logic [7:0]        o_exp_idx,
    input  logic [DATA_W-1:0] i_exp_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [7:0]        o_err_count,
    output logic [7:0]        o_first_err_idx
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_ELEMS - 1);

    mm_state_e         r_state, w_state_nxt;
    logic              w_fall, w_launch, w_last_issued, w_mismatch;
    logic              w_busy, w_done;
    logic              r_dram_read;
    logic [ADDR_W-1:0] r_dram_addr;
    logic [7:0]        r_idx;
    logic              r_cmp_vld;
    logic [7:0]        r_cmp_idx;
    logic [7:0]        r_err_count;
    logic [7:0]        r_first_err;
    logic              r_pass;

    mm_busy_fall_det u_fall_det (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_busy  (i_mm_busy),
        .o_fall  (w_fall)
    );

    assign w_launch      = (r_state == ST_IDLE) && w_fall && i_en;
    assign w_last_issued = (r_state == ST_READ) && (r_idx == LAST_IDX);
    assign w_mismatch    = r_cmp_vld && (i_dram_data != i_exp_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_busy = 1'b1;
                if (w_last_issued) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read address/index are registered one cycle ahead so the strobe lines up with
    // the READ state and the outputs hold their last value once reading stops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dram_read <= 1'b0;
            r_dram_addr <= '0;
            r_idx       <= '0;
        end else if (w_launch) begin
            r_dram_read <= 1'b1;
            r_dram_addr <= BASE_ADDR;
            r_idx       <= '0;
        end else if (r_state == ST_READ) begin
            if (w_last_issued) begin
                r_dram_read <= 1'b0;
            end else begin
                r_dram_read <= 1'b1;
                r_idx       <= r_idx + 8'd1;
                r_dram_addr <= BASE_ADDR + ADDR_W'(r_idx + 8'd1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmp_vld <= 1'b0;
            r_cmp_idx <= '0;
        end else begin
            r_cmp_vld <= r_dram_read;
            r_cmp_idx <= r_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= '0;
            r_first_err <= MM_NO_ERR_IDX;
        end else if (w_launch) begin
            r_err_count <= '0;
            r_first_err <= MM_NO_ERR_IDX;
        end else if (w_mismatch) begin
            r_err_count <= sat_inc8(r_err_count);
            if (r_first_err == MM_NO_ERR_IDX) r_first_err <= r_cmp_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_pass <= (r_err_count == 8'd0);
        end
    end

    assign o_dram_read     = r_dram_read;
    assign o_dram_addr     = r_dram_addr;
    assign o_exp_idx       = r_idx;
    assign o_busy          = w_busy;
    assign o_done          = w_done;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err_count;
    assign o_first_err_idx = r_first_err;

endmodule
